dmem_arbiter: RTL and testbench

- Shares the single data-memory port (comb read, write on clk edge) between the pipelined RV32I core's data port and a debug/loader master.
- Sits between the core's memory-stage outputs and the data memory.
- Arbitrates per cycle with round-robin and supports a bounded debug lock for burst transfers.
- Returns read data to each master and a stall to the core when it is not granted.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arbiter_rr_arb2.sv | 28 ++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and owner ids.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    YIELD = 2'd2
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational round-robin picker with an optional fixed-priority override.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       prio_en,
  input  logic       prio_sel,
  output logic [1:0] gnt
);

  logic other_sel;
  logic rr_sel;

  assign other_sel = ~prio_sel;
  assign rr_sel    = ~last_gnt;

  always_comb begin
    gnt = '0;
    if (prio_en) begin
      if (req[prio_sel]) gnt[prio_sel]  = 1'b1;
      else               gnt[other_sel] = req[other_sel];
    end else if (req == 2'b11) begin
      gnt[rr_sel] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core data port and a debug/loader master,
// round-robin per cycle with a bounded debug burst lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_gnt,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t       state, state_nxt;
  logic             last_gnt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic [1:0]       rr_gnt;
  logic             lock_full;

  assign lock_full = (lock_cnt == CNT_W'(MAX_LOCK));

  rr_arb2 u_rr (
    .req      ({d_req, c_req}),
    .last_gnt (last_gnt),
    .prio_en  (state == YIELD),
    .prio_sel (OWN_CORE),
    .gnt      (rr_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      last_gnt <= OWN_DBG;
      lock_cnt <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (d_gnt)      last_gnt <= OWN_DBG;
      else if (c_gnt) last_gnt <= OWN_CORE;
      d_rvalid <= d_gnt & ~d_we;
      if (d_gnt && !d_we) d_rdata <= m_rdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB: begin
        if (d_gnt && d_lock) begin
          state_nxt    = LOCK;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCK: begin
        if (!d_req || !d_lock) begin
          state_nxt    = ARB;
          lock_cnt_nxt = '0;
        end else if (lock_full) begin
          state_nxt = YIELD;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      YIELD: begin
        state_nxt    = ARB;
        lock_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = ARB;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // Grants are suppressed while reset is held so no write reaches memory during reset.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (state == LOCK && d_req) begin
        d_gnt = ~d_lock | ~lock_full;
      end else begin
        c_gnt = rr_gnt[OWN_CORE];
        d_gnt = rr_gnt[OWN_DBG];
      end
    end
  end

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign c_rdata = c_gnt ? m_rdata : '0;
  assign c_stall = c_req & ~c_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_gnt, c_stall;
  logic        d_req, d_we, d_lock;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_gnt, d_rvalid;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [31:0] mem [0:255] = '{default: '0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) if (m_we) mem[m_addr[9:2]] <= m_wdata;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(16)) dut (
    .clk(clk), .reset(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_gnt(c_gnt), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got c=%b d=%b expected 0 0", c_gnt, d_gnt); end
    checks++; if (m_we !== 1'b0 || m_addr !== 32'h0) begin errors++; $display("FAIL reset_mem: got we=%b addr=%h expected 0 0", m_we, m_addr); end
    checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_dbg: got rvalid=%b rdata=%h expected 0 0", d_rvalid, d_rdata); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_core_write_read();
    c_req = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (c_gnt !== 1'b1 || c_stall !== 1'b0) begin errors++; $display("FAIL core_wr_gnt: got gnt=%b stall=%b expected 1 0", c_gnt, c_stall); end
    checks++; if (m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_wr_bus: got we=%b addr=%h data=%h expected 1 00000040 deadbeef", m_we, m_addr, m_wdata); end
    tick();
    c_we = 0;
    #1;
    checks++; if (c_rdata !== 32'hDEADBEEF || c_stall !== 1'b0) begin errors++; $display("FAIL core_rd: got rdata=%h stall=%b expected deadbeef 0", c_rdata, c_stall); end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    c_req = 1; c_we = 1; c_addr = 32'h44; c_wdata = 32'h12345678;
    tick();
    reset_dut();
    c_req = 1; c_we = 0; c_addr = 32'h40;
    d_req = 1; d_we = 0; d_lock = 0; d_addr = 32'h44;
    for (int i = 0; i < 6; i++) begin
      logic exp_core;
      logic exp_rv;
      exp_core = (i % 2 == 0);
      exp_rv   = (i > 0) && (i % 2 == 0);
      #1;
      checks++; if (c_gnt !== exp_core || d_gnt !== !exp_core) begin errors++; $display("FAIL rr_gnt[%0d]: got c=%b d=%b expected c=%b", i, c_gnt, d_gnt, exp_core); end
      checks++; if (c_stall !== !exp_core) begin errors++; $display("FAIL rr_stall[%0d]: got %b expected %b", i, c_stall, !exp_core); end
      checks++; if (c_rdata !== (exp_core ? 32'hDEADBEEF : 32'h0)) begin errors++; $display("FAIL rr_crdata[%0d]: got %h", i, c_rdata); end
      checks++; if (d_rvalid !== exp_rv) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, d_rvalid, exp_rv); end
      if (exp_rv) begin
        checks++; if (d_rdata !== 32'h12345678) begin errors++; $display("FAIL rr_drdata[%0d]: got %h expected 12345678", i, d_rdata); end
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin errors++; $display("FAIL rr_last_rvalid: got %b %h expected 1 12345678", d_rvalid, d_rdata); end
    tick();
  endtask

  task automatic test_lock_bound();
    c_req = 1; c_we = 0; c_addr = 32'h40;
    tick();
    c_we = 1; c_addr = 32'h80; c_wdata = 32'hCAFEF00D;
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h44;
    for (int i = 0; i < 20; i++) begin
      logic exp_c;
      logic exp_d;
      exp_c = (i == 17);
      exp_d = (i < 16) || (i >= 18);
      #1;
      checks++; if (c_gnt !== exp_c || d_gnt !== exp_d) begin errors++; $display("FAIL lock_gnt[%0d]: got c=%b d=%b expected c=%b d=%b", i, c_gnt, d_gnt, exp_c, exp_d); end
      if (i == 16) begin
        checks++; if (m_we !== 1'b0 || c_stall !== 1'b1) begin errors++; $display("FAIL lock_dead: got we=%b stall=%b expected 0 1", m_we, c_stall); end
      end
      if (i == 17) begin
        checks++; if (m_we !== 1'b1 || m_addr !== 32'h80 || m_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL lock_yield_wr: got we=%b addr=%h data=%h", m_we, m_addr, m_wdata); end
      end
      tick();
    end
    clear_inputs();
    c_req = 1; c_addr = 32'h80;
    #1;
    checks++; if (c_gnt !== 1'b1 || c_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL lock_release_rd: got gnt=%b rdata=%h expected 1 cafef00d", c_gnt, c_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_debug_burst();
    c_req = 1; c_we = 0; c_addr = 32'h108;
    for (int k = 0; k < 4; k++) begin
      d_req = 1; d_we = 1; d_lock = (k < 3);
      d_addr = 32'h100 + 32'(4 * k); d_wdata = 32'(k + 1);
      #1;
      checks++; if (d_gnt !== 1'b1 || c_gnt !== 1'b0 || c_stall !== 1'b1) begin errors++; $display("FAIL burst_gnt[%0d]: got d=%b c=%b stall=%b expected 1 0 1", k, d_gnt, c_gnt, c_stall); end
      checks++; if (m_we !== 1'b1 || m_addr !== 32'h100 + 32'(4 * k) || m_wdata !== 32'(k + 1)) begin errors++; $display("FAIL burst_bus[%0d]: got we=%b addr=%h data=%h", k, m_we, m_addr, m_wdata); end
      tick();
    end
    d_req = 0; d_we = 0; d_lock = 0;
    #1;
    checks++; if (c_gnt !== 1'b1 || c_rdata !== 32'h3) begin errors++; $display("FAIL burst_core_rd: got gnt=%b rdata=%h expected 1 00000003", c_gnt, c_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    reset_dut();
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h100;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL mid_first_gnt: got %b expected 1", d_gnt); end
    tick();
    #1;
    checks++; if (d_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'h1) begin errors++; $display("FAIL mid_lock_beat: got gnt=%b rvalid=%b rdata=%h expected 1 1 00000001", d_gnt, d_rvalid, d_rdata); end
    rst = 1'b1;
    c_req = 1;
    #1;
    checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || m_we !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: got c=%b d=%b we=%b expected 0 0 0", c_gnt, d_gnt, m_we); end
    tick();
    checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rvalid: got rvalid=%b rdata=%h expected 0 0", d_rvalid, d_rdata); end
    checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL mid_rst_held: got c=%b d=%b expected 0 0", c_gnt, d_gnt); end
    clear_inputs();
    rst = 1'b0;
    tick();
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL mid_post_rvalid: got %b expected 0", d_rvalid); end
    c_req = 1; c_addr = 32'h40; d_req = 1; d_lock = 0; d_addr = 32'h100;
    #1;
    checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL mid_post_arb: got c=%b d=%b expected 1 0", c_gnt, d_gnt); end
    tick();
    clear_inputs();
  endtask

  task automatic test_idle();
    d_req = 1; d_addr = 32'h104;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL idle_pre_gnt: got %b expected 1", d_gnt); end
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || m_we !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL idle[%0d]: got c=%b d=%b we=%b addr=%h wdata=%h expected all 0", i, c_gnt, d_gnt, m_we, m_addr, m_wdata); end
      tick();
    end
    c_req = 1; c_addr = 32'h40; d_req = 1; d_addr = 32'h104;
    #1;
    checks++; if (c_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL idle_tie1: got c=%b d=%b expected 1 0", c_gnt, d_gnt); end
    tick();
    #1;
    checks++; if (c_gnt !== 1'b0 || d_gnt !== 1'b1) begin errors++; $display("FAIL idle_tie2: got c=%b d=%b expected 0 1", c_gnt, d_gnt); end
    tick();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_core_write_read();
    test_round_robin();
    test_lock_bound();
    test_debug_burst();
    test_reset_mid_read();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
